commit_checker: RTL

Synthesizable in-simulation golden-trace checker. It sits alongside the processor hierarchy and taps the same retirement signals the processor bench logs. It takes one expected per-instruction commit record at a time from a loader (valid/ready), buffers them in a small FIFO, and compares each DUT commit against the FIFO head. It reports pass, fail, first mismatch index and counters, and stops at the first error or at a matched halt.

---
 rtl/commit_pkg.sv | 24 ++
 rtl/commit_fifo.sv | 57 +++++
 rtl/commit_checker.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/commit_pkg.sv
// Shared definitions for the golden-trace commit checker: record layout and FSM states.
package commit_pkg;

  // Expected commit record: 55 bits, flags in the top nibble.
  localparam int unsigned REC_W         = 55;
  localparam int unsigned DATA_W        = 16;
  localparam int unsigned WREG_W        = 3;

  localparam int unsigned REC_REG_WE    = 54;
  localparam int unsigned REC_MEM_RD    = 53;
  localparam int unsigned REC_MEM_WR    = 52;
  localparam int unsigned REC_HALT      = 51;
  localparam int unsigned REC_WREG_LSB  = 48;
  localparam int unsigned REC_WDATA_LSB = 32;
  localparam int unsigned REC_ADDR_LSB  = 16;
  localparam int unsigned REC_MDATA_LSB = 0;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_DONE = 2'd1,
    ST_FAIL = 2'd2
  } state_e;

endpackage

// File: rtl/commit_fifo.sv
// Synchronous FIFO for expected commit records; head is read directly from storage registers.
module commit_fifo #(
  parameter int unsigned WIDTH = 55,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok;
  logic             pop_ok;

  // Extra pointer MSB distinguishes full (MSBs differ) from empty (pointers equal).
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Pointer advance; guarded so overflow/underflow requests are dropped.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Pointer registers; reset empties the FIFO (storage contents become don't-care).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Record storage; no reset needed since empty pointers mask stale data.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/commit_checker.sv
// Golden-trace checker: compares each DUT retirement against the next expected record.
module commit_checker
  import commit_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CYC_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [54:0]       exp_rec,
  input  logic              RegWrite,
  input  logic [2:0]        WriteRegister,
  input  logic [15:0]       WriteData,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [15:0]       MemAddress,
  input  logic [15:0]       MemDataIn,
  input  logic [15:0]       MemDataOut,
  input  logic              Halt,
  output logic              done,
  output logic              fail,
  output logic              starved,
  output logic [15:0]       mismatch_idx,
  output logic [15:0]       inst_count,
  output logic [CYC_W-1:0]  cycle_count
);

  state_e             state_q, state_d;
  logic               starved_q, starved_d;
  logic [DATA_W-1:0]  mismatch_idx_q, mismatch_idx_d;
  logic [DATA_W-1:0]  inst_count_q, inst_count_d;
  logic [CYC_W-1:0]   cycle_count_q, cycle_count_d;

  logic [REC_W-1:0]   head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               commit_c;
  logic               match_c;

  // Loader handshake; deliberately not pop-aware so a full FIFO never accepts.
  assign exp_ready = ~rst & (state_q == ST_RUN) & ~fifo_full;
  assign push      = exp_valid & exp_ready;

  commit_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (exp_rec),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign commit_c = RegWrite | MemRead | MemWrite | Halt;

  // Field comparison against the FIFO head; unflagged fields are ignored.
  always_comb begin
    logic flags_ok;
    logic reg_ok;
    logic addr_ok;
    logic rd_ok;
    logic wr_ok;
    flags_ok = ({head[REC_REG_WE], head[REC_MEM_RD], head[REC_MEM_WR], head[REC_HALT]} ==
                {RegWrite, MemRead, MemWrite, Halt});
    reg_ok   = ~head[REC_REG_WE] |
               ((head[REC_WREG_LSB +: WREG_W] == WriteRegister) &&
                (head[REC_WDATA_LSB +: DATA_W] == WriteData));
    addr_ok  = ~(head[REC_MEM_RD] | head[REC_MEM_WR]) |
               (head[REC_ADDR_LSB +: DATA_W] == MemAddress);
    rd_ok    = ~head[REC_MEM_RD] | (head[REC_MDATA_LSB +: DATA_W] == MemDataOut);
    wr_ok    = ~head[REC_MEM_WR] | (head[REC_MDATA_LSB +: DATA_W] == MemDataIn);
    match_c  = flags_ok & reg_ok & addr_ok & rd_ok & wr_ok;
  end

  // Next-state, pop and counter updates; terminal states freeze everything.
  always_comb begin
    state_d        = state_q;
    starved_d      = starved_q;
    mismatch_idx_d = mismatch_idx_q;
    inst_count_d   = inst_count_q;
    cycle_count_d  = cycle_count_q;
    pop            = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (cycle_count_q != {CYC_W{1'b1}}) begin
          cycle_count_d = cycle_count_q + CYC_W'(1);
        end
        if (commit_c) begin
          if (fifo_empty) begin
            state_d        = ST_FAIL;
            starved_d      = 1'b1;
            mismatch_idx_d = inst_count_q;
          end else begin
            pop = 1'b1;
            if (!match_c) begin
              state_d        = ST_FAIL;
              mismatch_idx_d = inst_count_q;
            end else if (head[REC_HALT]) begin
              state_d = ST_DONE;
            end else begin
              inst_count_d = inst_count_q + DATA_W'(1);
            end
          end
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_RUN;
      starved_q      <= 1'b0;
      mismatch_idx_q <= '0;
      inst_count_q   <= '0;
      cycle_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      starved_q      <= starved_d;
      mismatch_idx_q <= mismatch_idx_d;
      inst_count_q   <= inst_count_d;
      cycle_count_q  <= cycle_count_d;
    end
  end

  assign done         = (state_q == ST_DONE);
  assign fail         = (state_q == ST_FAIL);
  assign starved      = starved_q;
  assign mismatch_idx = mismatch_idx_q;
  assign inst_count   = inst_count_q;
  assign cycle_count  = cycle_count_q;

endmodule
